vscpu_loader: RTL and testbench

Boot-time program loader placed upstream of the CPU's block RAM. It accepts a byte stream from a host interface (UART receiver or testbench driver), packs the bytes into 32-bit words, and writes them into the RAM from address 0 upward. It holds the CPU in reset until a complete, checksum-verified image is in memory, then releases the CPU and takes no further part in operation.

---
 rtl/vscpu_pkg.sv | 17 +
 rtl/vscpu_word_packer.sv | 29 ++
 rtl/vscpu_loader.sv | 139 +++++++++++++
 tb/tb_vscpu_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vscpu_pkg.sv
// Shared constants and state encoding for the boot-time program loader.
package vscpu_pkg;

   localparam int VSCPU_ADDR_LEN  = 14;
   localparam int VSCPU_MEM_DEPTH = 16384;
   localparam int CSUM_W          = 8;

   typedef enum logic [2:0] {
      ST_HDR0,
      ST_HDR1,
      ST_DATA,
      ST_CSUM,
      ST_RUN,
      ST_ERROR
   } ld_state_t;

endpackage

// File: rtl/vscpu_word_packer.sv
// Packs a little-endian byte stream into 32-bit words; the completed word and
// its valid pulse are presented combinationally alongside the 4th byte strobe.
module vscpu_word_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  i_byte,
   input  logic        i_stb,
   output logic [31:0] o_word,
   output logic        o_word_valid
);

   logic [23:0] r_shift;
   logic [1:0]  r_cnt;

   // Earlier bytes sit in the low lanes, so the newest byte lands in [31:24].
   assign o_word       = {i_byte, r_shift};
   assign o_word_valid = i_stb && (r_cnt == 2'd3);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (i_stb) begin
         r_shift <= {i_byte, r_shift[23:8]};
         r_cnt   <= r_cnt + 2'd1;
      end
   end

endmodule

// File: rtl/vscpu_loader.sv
// Boot loader: receives a counted, checksummed byte image, writes it to RAM
// from word 0 upward and releases the CPU from reset once the image verifies.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_HDR0  | waiting for word-count high byte
//  ST_HDR1  | waiting for word-count low byte; range-checks the count
//  ST_DATA  | packing data bytes and striking RAM writes
//  ST_CSUM  | waiting for checksum byte
//  ST_RUN   | image good, CPU released (terminal)
//  ST_ERROR | oversize count or checksum mismatch (terminal)
module vscpu_loader
   import vscpu_pkg::*;
#(
   parameter int ADDR_LEN  = VSCPU_ADDR_LEN,
   parameter int MEM_DEPTH = VSCPU_MEM_DEPTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_in_valid,
   output logic                o_in_ready,
   input  logic [7:0]          i_in_byte,
   output logic                o_ram_we,
   output logic [ADDR_LEN-1:0] o_ram_addr,
   output logic [31:0]         o_ram_data,
   output logic                o_cpu_rst,
   output logic                o_done,
   output logic                o_err
);

   ld_state_t           r_state;
   logic [7:0]          r_n_hi;
   logic [15:0]         r_remain;
   logic [ADDR_LEN-1:0] r_idx;
   logic [CSUM_W-1:0]   r_xor;

   logic                r_in_ready;
   logic                r_ram_we;
   logic [ADDR_LEN-1:0] r_ram_addr;
   logic [31:0]         r_ram_data;
   logic                r_cpu_rst;
   logic                r_done;
   logic                r_err;

   logic                w_accept;
   logic                w_pack_stb;
   logic [31:0]         w_word;
   logic                w_word_valid;
   logic [15:0]         w_n;
   logic                w_n_over;

   assign w_accept   = i_in_valid && r_in_ready;
   assign w_pack_stb = w_accept && (r_state == ST_DATA);
   assign w_n        = {r_n_hi, i_in_byte};
   assign w_n_over   = {16'd0, w_n} > 32'(MEM_DEPTH);

   vscpu_word_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .i_byte       (i_in_byte),
      .i_stb        (w_pack_stb),
      .o_word       (w_word),
      .o_word_valid (w_word_valid)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= ST_HDR0;
         r_n_hi     <= '0;
         r_remain   <= '0;
         r_idx      <= '0;
         r_xor      <= '0;
         r_in_ready <= 1'b1;
         r_ram_we   <= 1'b0;
         r_ram_addr <= '0;
         r_ram_data <= '0;
         r_cpu_rst  <= 1'b1;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_ram_we <= 1'b0;
         if (w_accept) begin
            unique case (r_state)
               ST_HDR0: begin
                  r_n_hi  <= i_in_byte;
                  r_xor   <= r_xor ^ i_in_byte;
                  r_state <= ST_HDR1;
               end
               ST_HDR1: begin
                  r_xor    <= r_xor ^ i_in_byte;
                  r_remain <= w_n;
                  if (w_n_over) begin
                     r_state    <= ST_ERROR;
                     r_in_ready <= 1'b0;
                     r_err      <= 1'b1;
                  end else if (w_n == 16'd0) begin
                     r_state <= ST_CSUM;
                  end else begin
                     r_state <= ST_DATA;
                  end
               end
               ST_DATA: begin
                  r_xor <= r_xor ^ i_in_byte;
                  if (w_word_valid) begin
                     r_ram_we   <= 1'b1;
                     r_ram_addr <= r_idx;
                     r_ram_data <= w_word;
                     r_idx      <= r_idx + 1'b1;
                     r_remain   <= r_remain - 16'd1;
                     // Terminal count on the remaining-word down-counter.
                     if (r_remain == 16'd1) r_state <= ST_CSUM;
                  end
               end
               ST_CSUM: begin
                  r_in_ready <= 1'b0;
                  if (i_in_byte == r_xor) begin
                     r_state   <= ST_RUN;
                     r_cpu_rst <= 1'b0;
                     r_done    <= 1'b1;
                  end else begin
                     r_state <= ST_ERROR;
                     r_err   <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign o_in_ready = r_in_ready;
   assign o_ram_we   = r_ram_we;
   assign o_ram_addr = r_ram_addr;
   assign o_ram_data = r_ram_data;
   assign o_cpu_rst  = r_cpu_rst;
   assign o_done     = r_done;
   assign o_err      = r_err;

endmodule

// File: tb/tb_vscpu_loader.sv
// Self-checking bench for vscpu_loader: directed vector table, hand-written
// reset/ignore sequences and randomized streams against a stream-level model.
module tb_vscpu_loader;

   typedef logic [7:0] bq_t[$];

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_in_valid = 1'b0;
   logic [7:0]  i_in_byte = 8'h00;
   logic        o_in_ready;
   logic        o_ram_we;
   logic [13:0] o_ram_addr;
   logic [31:0] o_ram_data;
   logic        o_cpu_rst;
   logic        o_done;
   logic        o_err;

   vscpu_loader #(.ADDR_LEN(14), .MEM_DEPTH(16384)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_in_valid (i_in_valid),
      .o_in_ready (o_in_ready),
      .i_in_byte  (i_in_byte),
      .o_ram_we   (o_ram_we),
      .o_ram_addr (o_ram_addr),
      .o_ram_data (o_ram_data),
      .o_cpu_rst  (o_cpu_rst),
      .o_done     (o_done),
      .o_err      (o_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   int          wr_addr[$];
   logic [31:0] wr_data[$];
   int          wr_cyc[$];
   int          acc_cyc[$];
   int          done_cyc = -1;
   int          err_cyc  = -1;

   // Observe the RAM port and first done/err on the falling edge.
   always @(negedge clk) begin
      if (rst && o_ram_we) begin
         wr_addr.push_back(int'(o_ram_addr));
         wr_data.push_back(o_ram_data);
         wr_cyc.push_back(cyc);
      end
      if (rst && o_done && done_cyc < 0) done_cyc = cyc;
      if (rst && o_err && err_cyc < 0) err_cyc = cyc;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_in_ready"}, 32'(o_in_ready), 32'd1);
      chk({tag, "_ram_we"},   32'(o_ram_we),   32'd0);
      chk({tag, "_ram_addr"}, 32'(o_ram_addr), 32'd0);
      chk({tag, "_ram_data"}, o_ram_data,      32'd0);
      chk({tag, "_cpu_rst"},  32'(o_cpu_rst),  32'd1);
      chk({tag, "_done"},     32'(o_done),     32'd0);
      chk({tag, "_err"},      32'(o_err),      32'd0);
   endtask

   task automatic do_reset(input bit check, input string tag);
      i_in_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      if (check) check_reset_vals(tag);
      rst = 1'b1;
      wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); acc_cyc.delete();
      done_cyc = -1;
      err_cyc  = -1;
   endtask

   // Offer each byte after a random idle gap; with must set, wait (bounded) for acceptance.
   task automatic send(input bq_t q, input int gap_max, input bit must);
      bit ok;
      bit rdy;
      for (int i = 0; i < q.size(); i++) begin
         int idle;
         idle = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
         repeat (idle) begin
            i_in_valid = 1'b0;
            i_in_byte  = 8'($urandom);
            @(posedge clk); #1;
         end
         i_in_valid = 1'b1;
         i_in_byte  = q[i];
         if (!must) begin
            @(posedge clk); #1;
         end else begin
            ok = 1'b0;
            for (int t = 0; t < 8 && !ok; t++) begin
               rdy = o_in_ready;
               @(posedge clk); #1;
               ok = rdy;
            end
            if (!ok) chk("accept_timeout", 32'd0, 32'd1);
            else acc_cyc.push_back(cyc);
         end
      end
      i_in_valid = 1'b0;
   endtask

   // Stream-level reference: decode header, words and checksum from the byte list.
   task automatic model_check(input bq_t s, input string tag);
      int n;
      int nw;
      logic [7:0]  ck;
      logic [31:0] w;
      bit good;
      repeat (2) @(posedge clk);
      #1;
      n = int'(s[0]) * 256 + int'(s[1]);
      if (n > 16384) begin
         chk({tag, "_nwr_over"},   32'(wr_data.size()), 32'd0);
         chk({tag, "_err_over"},   32'(o_err), 32'd1);
         chk({tag, "_errcyc_over"}, 32'(err_cyc), 32'(acc_cyc[1]));
         chk({tag, "_cpurst_over"}, 32'(o_cpu_rst), 32'd1);
         chk({tag, "_done_over"},  32'(o_done), 32'd0);
         chk({tag, "_rdy_over"},   32'(o_in_ready), 32'd0);
         return;
      end
      ck = 8'h00;
      for (int i = 0; i < 2 + 4 * n; i++) ck = ck ^ s[i];
      good = (ck == s[2 + 4 * n]);
      chk({tag, "_nwr"}, 32'(wr_data.size()), 32'(n));
      nw = (wr_data.size() < n) ? wr_data.size() : n;
      for (int i = 0; i < nw; i++) begin
         w = {s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]};
         chk({tag, "_wr_addr"}, 32'(wr_addr[i]), 32'(i));
         chk({tag, "_wr_data"}, wr_data[i], w);
         if (acc_cyc.size() == s.size())
            chk({tag, "_wr_cyc"}, 32'(wr_cyc[i]), 32'(acc_cyc[2+4*i+3]));
      end
      chk({tag, "_done"},    32'(o_done),    32'(good));
      chk({tag, "_err"},     32'(o_err),     32'(!good));
      chk({tag, "_cpu_rst"}, 32'(o_cpu_rst), 32'(!good));
      chk({tag, "_rdy"},     32'(o_in_ready), 32'd0);
      if (acc_cyc.size() == s.size()) begin
         if (good) chk({tag, "_rel_cyc"}, 32'(done_cyc), 32'(acc_cyc[2+4*n]));
         else      chk({tag, "_err_cyc"}, 32'(err_cyc),  32'(acc_cyc[2+4*n]));
      end
   endtask

   function automatic bq_t rand_stream(input int n, input bit good);
      bq_t s;
      logic [7:0] ck;
      s.push_back(8'(n >> 8));
      s.push_back(8'(n));
      for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
      ck = 8'h00;
      foreach (s[i]) ck = ck ^ s[i];
      s.push_back(good ? ck : ~ck);
      return s;
   endfunction

   typedef struct {
      int           len;
      logic [119:0] data;
      int           n_wr;
      logic [31:0]  w0;
      logic [31:0]  wl;
      bit           done;
      bit           err;
   } vec_t;

   vec_t tbl[5];

   initial begin
      bq_t q;
      bq_t junk;
      int  nwr;

      tbl[0] = '{7,  120'h00014433221145,         1, 32'h11223344, 32'h11223344, 1'b1, 1'b0};
      tbl[1] = '{7,  120'h00014433221146,         1, 32'h11223344, 32'h11223344, 1'b0, 1'b1};
      tbl[2] = '{3,  120'h000000,                 0, 32'h0,        32'h0,        1'b1, 1'b0};
      tbl[3] = '{2,  120'h4001,                   0, 32'h0,        32'h0,        1'b0, 1'b1};
      tbl[4] = '{11, 120'h000201020304aabbccdd06, 2, 32'h04030201, 32'hddccbbaa, 1'b1, 1'b0};

      junk = '{8'h12, 8'h34, 8'h56};

      repeat (2) @(posedge clk);
      do_reset(1'b1, "por");

      foreach (tbl[k]) begin
         vec_t v;
         string tag;
         v = tbl[k];
         tag = $sformatf("vec%0d", k);
         do_reset(1'b0, tag);
         q.delete();
         for (int i = 0; i < v.len; i++) q.push_back(v.data[8*(v.len-1-i) +: 8]);
         send(q, 0, 1'b1);
         if (acc_cyc.size() == v.len)
            chk({tag, "_no_stall"}, 32'(acc_cyc[v.len-1] - acc_cyc[0]), 32'(v.len - 1));
         model_check(q, tag);
         chk({tag, "_t_nwr"},  32'(wr_data.size()), 32'(v.n_wr));
         if (v.n_wr > 0 && wr_data.size() == v.n_wr) begin
            chk({tag, "_t_w0"}, wr_data[0], v.w0);
            chk({tag, "_t_wl"}, wr_data[v.n_wr-1], v.wl);
         end
         chk({tag, "_t_done"}, 32'(o_done), 32'(v.done));
         chk({tag, "_t_err"},  32'(o_err),  32'(v.err));
         nwr = wr_data.size();
         send(junk, 0, 1'b0);
         repeat (2) @(posedge clk);
         #1;
         chk({tag, "_ign_nwr"},  32'(wr_data.size()), 32'(nwr));
         chk({tag, "_ign_rdy"},  32'(o_in_ready), 32'd0);
         chk({tag, "_ign_done"}, 32'(o_done), 32'(v.done));
         chk({tag, "_ign_err"},  32'(o_err),  32'(v.err));
      end

      // Reset two bytes into the data phase, then load the nominal image.
      do_reset(1'b0, "mid");
      q = '{8'h00, 8'h01, 8'h44, 8'h33};
      send(q, 0, 1'b1);
      do_reset(1'b1, "mid_rst");
      q = '{8'h00, 8'h01, 8'h44, 8'h33, 8'h22, 8'h11, 8'h45};
      send(q, 0, 1'b1);
      model_check(q, "mid_load");
      if (wr_data.size() == 1) chk("mid_load_w0", wr_data[0], 32'h11223344);

      for (int r = 0; r < 6; r++) begin
         do_reset(1'b0, "gap3");
         q = rand_stream(3, 1'b1);
         send(q, 3, 1'b1);
         model_check(q, $sformatf("gap3w_%0d", r));
      end

      for (int r = 0; r < 12; r++) begin
         int n;
         bit good;
         n = int'($urandom_range(0, 5));
         good = ($urandom_range(0, 3) != 0);
         do_reset(1'b0, "rnd");
         q = rand_stream(n, good);
         send(q, int'($urandom_range(0, 2)), 1'b1);
         model_check(q, $sformatf("rnd_%0d", r));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
